// File: rtl/servo_pkg.sv
// Shared servo command and timing definitions, also used by the UART command decoder.
package servo_pkg;

    localparam int MOTOR_W       = 3;
    localparam int ANGLE_W       = 8;
    localparam int DEF_CLK_HZ    = 50_000_000;
    localparam int DEF_FRAME_US  = 20_000;
    localparam int DEF_MIN_US    = 1_000;
    localparam int DEF_MAX_US    = 2_000;
    localparam int DEF_ANGLE_MAX = 180;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_UPD = 1'b1
    } upd_state_e;

    // Ticks per microsecond is taken as a whole number before scaling.
    function automatic int us_to_ticks(input int clk_hz, input int us);
        return (clk_hz / 32'sd1_000_000) * us;
    endfunction

    function automatic int deg_to_ticks(input int clk_hz, input int min_us,
                                        input int max_us, input int angle_max);
        longint num;
        longint den;
        num = longint'(clk_hz) * longint'(max_us - min_us);
        den = 64'sd1_000_000 * longint'(angle_max);
        return int'(num / den);
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame counter for the servo bank: wraps every FRAME_TICKS, flags the last tick
// (update trigger) and emits a frame_start pulse aligned with the registered pwm.
module servo_frame_timer #(
    parameter int FRAME_TICKS = 1_000_000,
    parameter int CNT_W       = $clog2(FRAME_TICKS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             frame_start,
    output logic             upd_trig
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_TICKS - 1);

    logic [CNT_W-1:0] frame_cnt_d;
    logic [CNT_W-1:0] frame_cnt_q;
    logic             frame_start_d;
    logic             frame_start_q;
    logic             wrap_s;

    // Next count with wrap; frame_start is registered so it lines up with pwm.
    always_comb begin
        wrap_s = (frame_cnt_q == LAST_CNT);
        if (wrap_s) begin
            frame_cnt_d = {CNT_W{1'b0}};
        end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1'b1);
        end
        frame_start_d = (frame_cnt_q == {CNT_W{1'b0}});
    end

    // Counter and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q   <= {CNT_W{1'b0}};
            frame_start_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_cnt   = frame_cnt_q;
    assign frame_start = frame_start_q;
    assign upd_trig    = wrap_s;

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel hobby-servo PWM bank: per-joint target/active angles, slewed and
// latched into pulse widths only during the first cycles of each frame.
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int NUM_MOTORS = 6,
    parameter int FRAME_US   = DEF_FRAME_US,
    parameter int MIN_US     = DEF_MIN_US,
    parameter int MAX_US     = DEF_MAX_US,
    parameter int ANGLE_MAX  = DEF_ANGLE_MAX,
    parameter int SLEW_DEG   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    input  logic [MOTOR_W-1:0]    motor,
    input  logic [ANGLE_W-1:0]    angle,
    output logic [NUM_MOTORS-1:0] pwm,
    output logic                  frame_start,
    output logic                  cmd_err
);

    localparam int FRAME_TICKS = us_to_ticks(CLK_HZ, FRAME_US);
    localparam int MIN_TICKS   = us_to_ticks(CLK_HZ, MIN_US);
    localparam int DEG_TICKS   = deg_to_ticks(CLK_HZ, MIN_US, MAX_US, ANGLE_MAX);
    localparam int CNT_W       = $clog2(FRAME_TICKS);

    localparam logic [ANGLE_W-1:0] ANGLE_MAX_C  = ANGLE_W'(ANGLE_MAX);
    localparam logic [ANGLE_W-1:0] ANGLE_CTR_C  = ANGLE_W'(ANGLE_MAX / 2);
    localparam logic [ANGLE_W-1:0] SLEW_C       = ANGLE_W'(SLEW_DEG);
    localparam logic [CNT_W-1:0]   WIDTH_CTR_C  = CNT_W'(MIN_TICKS + (ANGLE_MAX / 2) * DEG_TICKS);
    localparam logic [MOTOR_W:0]   NUM_MOTORS_C = (MOTOR_W + 1)'(NUM_MOTORS);
    localparam logic [MOTOR_W-1:0] LAST_IDX_C   = MOTOR_W'(NUM_MOTORS - 1);

    logic [CNT_W-1:0]      frame_cnt_s;
    logic                  upd_trig_s;

    upd_state_e            state_d, state_q;
    logic [MOTOR_W-1:0]    idx_d, idx_q;
    logic [ANGLE_W-1:0]    target_d [NUM_MOTORS];
    logic [ANGLE_W-1:0]    target_q [NUM_MOTORS];
    logic [ANGLE_W-1:0]    active_d [NUM_MOTORS];
    logic [ANGLE_W-1:0]    active_q [NUM_MOTORS];
    logic [CNT_W-1:0]      width_d  [NUM_MOTORS];
    logic [CNT_W-1:0]      width_q  [NUM_MOTORS];
    logic [NUM_MOTORS-1:0] pwm_d, pwm_q;
    logic                  cmd_err_d, cmd_err_q;

    logic                  motor_ok_s;
    logic [ANGLE_W-1:0]    angle_clamped_s;
    logic [ANGLE_W-1:0]    cur_target_s;
    logic [ANGLE_W-1:0]    cur_active_s;
    logic [ANGLE_W-1:0]    diff_s;
    logic [ANGLE_W-1:0]    step_s;
    logic [CNT_W-1:0]      step_width_s;

    servo_frame_timer #(
        .FRAME_TICKS (FRAME_TICKS),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_cnt   (frame_cnt_s),
        .frame_start (frame_start),
        .upd_trig    (upd_trig_s)
    );

    // Command qualification: range check on the channel, clamp on the angle.
    always_comb begin
        motor_ok_s = ({1'b0, motor} < NUM_MOTORS_C);
        if (angle > ANGLE_MAX_C) begin
            angle_clamped_s = ANGLE_MAX_C;
        end else begin
            angle_clamped_s = angle;
        end
    end

    // Next active angle for the channel under update, stepping toward its target.
    always_comb begin
        cur_target_s = target_q[idx_q];
        cur_active_s = active_q[idx_q];
        if (cur_target_s >= cur_active_s) begin
            diff_s = cur_target_s - cur_active_s;
        end else begin
            diff_s = cur_active_s - cur_target_s;
        end
        if ((SLEW_C == 8'd0) || (diff_s <= SLEW_C)) begin
            step_s = cur_target_s;
        end else if (cur_target_s > cur_active_s) begin
            step_s = cur_active_s + SLEW_C;
        end else begin
            step_s = cur_active_s - SLEW_C;
        end
        step_width_s = CNT_W'(MIN_TICKS + int'(step_s) * DEG_TICKS);
    end

    // Target writes plus the RUN/UPD sequencer; UPD reads the pre-write target.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        target_d  = target_q;
        active_d  = active_q;
        width_d   = width_q;
        cmd_err_d = 1'b0;

        if (cmd_valid) begin
            if (motor_ok_s) begin
                target_d[motor] = angle_clamped_s;
            end else begin
                cmd_err_d = 1'b1;
            end
        end else begin
            cmd_err_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (upd_trig_s) begin
                    state_d = ST_UPD;
                    idx_d   = {MOTOR_W{1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_UPD: begin
                active_d[idx_q] = step_s;
                width_d[idx_q]  = step_width_s;
                if (idx_q == LAST_IDX_C) begin
                    state_d = ST_RUN;
                    idx_d   = {MOTOR_W{1'b0}};
                end else begin
                    idx_d   = idx_q + MOTOR_W'(1'b1);
                end
            end
            default: begin
                state_d = ST_RUN;
                idx_d   = {MOTOR_W{1'b0}};
            end
        endcase
    end

    // Pulse compare against the live widths.
    always_comb begin
        for (int i = 0; i < NUM_MOTORS; i++) begin
            pwm_d[i] = (frame_cnt_s < width_q[i]);
        end
    end

    // State registers; reset parks every joint at center.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            idx_q     <= {MOTOR_W{1'b0}};
            pwm_q     <= {NUM_MOTORS{1'b0}};
            cmd_err_q <= 1'b0;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                target_q[i] <= ANGLE_CTR_C;
                active_q[i] <= ANGLE_CTR_C;
                width_q[i]  <= WIDTH_CTR_C;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pwm_q     <= pwm_d;
            cmd_err_q <= cmd_err_d;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                target_q[i] <= target_d[i];
                active_q[i] <= active_d[i];
                width_q[i]  <= width_d[i];
            end
        end
    end

    assign pwm     = pwm_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank: measures per-frame pulse widths and checks them
// against hand-computed values (1 MHz clock, DEG_TICKS = 5, center = 1450 ticks).
module tb_servo_pwm_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid_a, cmd_valid_b;
    logic [2:0] motor_a, motor_b;
    logic [7:0] angle_a, angle_b;
    logic [5:0] pwm_a, pwm_b;
    logic       frame_start_a, frame_start_b;
    logic       cmd_err_a, cmd_err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    servo_pwm_bank #(
        .CLK_HZ(1_000_000), .NUM_MOTORS(6), .FRAME_US(20000),
        .MIN_US(1000), .MAX_US(2000), .ANGLE_MAX(180), .SLEW_DEG(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_a), .motor(motor_a),
        .angle(angle_a), .pwm(pwm_a), .frame_start(frame_start_a), .cmd_err(cmd_err_a)
    );

    // Slew instance uses a short frame; pulse widths do not depend on frame length.
    servo_pwm_bank #(
        .CLK_HZ(1_000_000), .NUM_MOTORS(6), .FRAME_US(2500),
        .MIN_US(1000), .MAX_US(2000), .ANGLE_MAX(180), .SLEW_DEG(10)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_b), .motor(motor_b),
        .angle(angle_b), .pwm(pwm_b), .frame_start(frame_start_b), .cmd_err(cmd_err_b)
    );

    int cyc = 0;
    int last_fs_a = 0, period_a = 0, frames_a = 0;
    int last_fs_b = 0, period_b = 0, frames_b = 0;
    int acc_a [6];
    int done_a [6];
    int acc_b0 = 0, done_b0 = 0;

    // Per-frame high-time accumulators, delimited by frame_start.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (frame_start_a) begin
            period_a  <= cyc - last_fs_a;
            last_fs_a <= cyc;
            frames_a  <= frames_a + 1;
            for (int i = 0; i < 6; i++) begin
                done_a[i] <= acc_a[i];
                acc_a[i]  <= int'(pwm_a[i]);
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                acc_a[i] <= acc_a[i] + int'(pwm_a[i]);
            end
        end
        if (frame_start_b) begin
            period_b  <= cyc - last_fs_b;
            last_fs_b <= cyc;
            frames_b  <= frames_b + 1;
            done_b0   <= acc_b0;
            acc_b0    <= int'(pwm_b[0]);
        end else begin
            acc_b0    <= acc_b0 + int'(pwm_b[0]);
        end
    end

    task automatic wait_frame_a();
        int  start;
        bit  got;
        start = frames_a;
        got   = 1'b0;
        for (int k = 0; k < 25000 && !got; k++) begin
            @(posedge clk);
            if (frames_a != start) got = 1'b1;
        end
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL wait_frame_a: frame_start seen=%0d required=1", got);
        end
    endtask

    task automatic wait_frame_b();
        int  start;
        bit  got;
        start = frames_b;
        got   = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(posedge clk);
            if (frames_b != start) got = 1'b1;
        end
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL wait_frame_b: frame_start seen=%0d required=1", got);
        end
    endtask

    task automatic send_a(input logic [2:0] m, input logic [7:0] a);
        @(posedge clk); #1;
        cmd_valid_a = 1'b1; motor_a = m; angle_a = a;
        @(posedge clk); #1;
        cmd_valid_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid_a = 1'b0; motor_a = 3'd0; angle_a = 8'd0;
        cmd_valid_b = 1'b0; motor_b = 3'd0; angle_b = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pwm_a !== 6'h00) begin errors++; $display("FAIL reset_pwm_a got %h expected 00", pwm_a); end
        checks++;
        if (frame_start_a !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b expected 0", frame_start_a); end
        checks++;
        if (cmd_err_a !== 1'b0) begin errors++; $display("FAIL reset_cmd_err got %b expected 0", cmd_err_a); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (pwm_a !== 6'h3f) begin errors++; $display("FAIL first_edge_pwm_a got %h expected 3f", pwm_a); end
        checks++;
        if (frame_start_a !== 1'b1) begin errors++; $display("FAIL first_edge_frame_start got %b expected 1", frame_start_a); end
        @(posedge clk); #1;
        checks++;
        if (frame_start_a !== 1'b0) begin errors++; $display("FAIL frame_start_one_cycle got %b expected 0", frame_start_a); end
    endtask

    task automatic test_commands();
        send_a(3'd2, 8'd0);
        checks++;
        if (cmd_err_a !== 1'b0) begin errors++; $display("FAIL cmd_err_on_valid got %b expected 0", cmd_err_a); end
        send_a(3'd1, 8'd250);
    endtask

    task automatic test_cmd_err();
        send_a(3'd7, 8'd10);
        checks++;
        if (cmd_err_a !== 1'b1) begin errors++; $display("FAIL cmd_err_pulse got %b expected 1", cmd_err_a); end
        @(posedge clk); #1;
        checks++;
        if (cmd_err_a !== 1'b0) begin errors++; $display("FAIL cmd_err_width got %b expected 0", cmd_err_a); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        cmd_valid_a = 1'b1; motor_a = 3'd3; angle_a = 8'd30;
        @(posedge clk); #1;
        angle_a = 8'd60;
        @(posedge clk); #1;
        cmd_valid_a = 1'b0;
    endtask

    task automatic test_slew();
        int exp_w [4] = '{1500, 1550, 1600, 1600};
        @(posedge clk); #1;
        cmd_valid_b = 1'b1; motor_b = 3'd0; angle_b = 8'd120;
        @(posedge clk); #1;
        cmd_valid_b = 1'b0;
        wait_frame_b();
        checks++;
        if (done_b0 !== 1450) begin errors++; $display("FAIL slew_current_frame got %0d expected 1450", done_b0); end
        for (int f = 0; f < 4; f++) begin
            wait_frame_b();
            checks++;
            if (done_b0 !== exp_w[f]) begin
                errors++;
                $display("FAIL slew_frame%0d got %0d expected %0d", f + 1, done_b0, exp_w[f]);
            end
        end
        checks++;
        if (period_b !== 2500) begin errors++; $display("FAIL slew_period got %0d expected 2500", period_b); end
    endtask

    task automatic test_frame_apply();
        int exp_w [6] = '{1450, 1900, 1000, 1300, 1450, 1450};
        wait_frame_a();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (done_a[i] !== 1450) begin
                errors++;
                $display("FAIL current_frame_ch%0d got %0d expected 1450", i, done_a[i]);
            end
        end
        wait_frame_a();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (done_a[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL next_frame_ch%0d got %0d expected %0d", i, done_a[i], exp_w[i]);
            end
        end
        checks++;
        if (period_a !== 20000) begin errors++; $display("FAIL frame_period got %0d expected 20000", period_a); end
    endtask

    task automatic test_reset_mid_pulse();
        repeat (698) @(posedge clk);
        #2;
        checks++;
        if (pwm_a !== 6'h3f) begin errors++; $display("FAIL pre_reset_pwm got %h expected 3f", pwm_a); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (pwm_a !== 6'h00) begin errors++; $display("FAIL async_reset_pwm_a got %h expected 00", pwm_a); end
        checks++;
        if (pwm_b !== 6'h00) begin errors++; $display("FAIL async_reset_pwm_b got %h expected 00", pwm_b); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_frame_a();
        wait_frame_a();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (done_a[i] !== 1450) begin
                errors++;
                $display("FAIL post_reset_ch%0d got %0d expected 1450", i, done_a[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_commands();
        test_cmd_err();
        test_back_to_back();
        test_slew();
        test_frame_apply();
        test_reset_mid_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
